// File: rtl/banked_gpr_file_if.sv
// Register-file access bundle: two read ports, one write port,
// high-half register load and pending-result reservation.
interface banked_gpr_file_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    localparam int DEPTH = 1 << ADDR_W;

    logic              readEn;
    logic [ADDR_W-1:0] regANum;
    logic [ADDR_W-1:0] regBNum;
    logic [DATA_W-1:0] regAOut;
    logic [DATA_W-1:0] regBOut;
    logic              regABusy;
    logic              regBBusy;
    logic              writeEn;
    logic [ADDR_W-1:0] regCNum;
    logic [DATA_W-1:0] regCIn;
    logic              hiWriteEn;
    logic [DATA_W-1:0] hiIn;
    logic [DATA_W-1:0] hiOut;
    logic              reserveEn;
    logic [ADDR_W-1:0] reserveNum;
    logic [DEPTH-1:0]  busyVec;

    modport master (
        output readEn, regANum, regBNum,
        output writeEn, regCNum, regCIn,
        output hiWriteEn, hiIn,
        output reserveEn, reserveNum,
        input  regAOut, regBOut, regABusy, regBBusy,
        input  hiOut, busyVec
    );

    modport slave (
        input  readEn, regANum, regBNum,
        input  writeEn, regCNum, regCIn,
        input  hiWriteEn, hiIn,
        input  reserveEn, reserveNum,
        output regAOut, regBOut, regABusy, regBBusy,
        output hiOut, busyVec
    );
endinterface

// File: rtl/banked_gpr_file.sv
// General-purpose register file with registered dual read, write-through
// bypass, auxiliary high register and per-register pending scoreboard.
module banked_gpr_file #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input logic              clk,
    input logic              rstN,
    banked_gpr_file_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              abusy_q, abusy_d;
    logic              bbusy_q, bbusy_d;

    logic c_is_zero, r_is_zero, a_is_zero, b_is_zero;
    logic wr_ok, rsv_ok, hit_a, hit_b;

    always_comb begin
        c_is_zero = (ZERO_REG != 0) && (bus.regCNum == '0);
        r_is_zero = (ZERO_REG != 0) && (bus.reserveNum == '0);
        a_is_zero = (ZERO_REG != 0) && (bus.regANum == '0);
        b_is_zero = (ZERO_REG != 0) && (bus.regBNum == '0);
        wr_ok     = bus.writeEn && !c_is_zero;
        rsv_ok    = bus.reserveEn && !r_is_zero;
        hit_a     = wr_ok && (bus.regCNum == bus.regANum);
        hit_b     = wr_ok && (bus.regCNum == bus.regBNum);

        regs_d = regs_q;
        if (wr_ok) regs_d[bus.regCNum] = bus.regCIn;

        hi_d = hi_q;
        if (bus.hiWriteEn) hi_d = bus.hiIn;

        // clear first so a same-index reserve wins
        busy_d = busy_q;
        if (wr_ok)  busy_d[bus.regCNum]   = 1'b0;
        if (rsv_ok) busy_d[bus.reserveNum] = 1'b1;

        a_d     = a_q;
        b_d     = b_q;
        abusy_d = abusy_q;
        bbusy_d = bbusy_q;
        if (bus.readEn) begin
            a_d     = a_is_zero ? '0 :
                      hit_a ? bus.regCIn : regs_q[bus.regANum];
            b_d     = b_is_zero ? '0 :
                      hit_b ? bus.regCIn : regs_q[bus.regBNum];
            abusy_d = busy_q[bus.regANum] && !hit_a && !a_is_zero;
            bbusy_d = busy_q[bus.regBNum] && !hit_b && !b_is_zero;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            hi_q    <= '0;
            busy_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            abusy_q <= 1'b0;
            bbusy_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
            hi_q    <= hi_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            abusy_q <= abusy_d;
            bbusy_q <= bbusy_d;
        end
    end

    assign bus.regAOut  = a_q;
    assign bus.regBOut  = b_q;
    assign bus.regABusy = abusy_q;
    assign bus.regBBusy = bbusy_q;
    assign bus.hiOut    = hi_q;
    assign bus.busyVec  = busy_q;
endmodule

// File: doc/banked_gpr_file.md
BANKED_GPR_FILE -- requirements
Module: banked_gpr_file

Interface
REQ-001 Parameter DATA_W, default 8, width of each register in bits.
REQ-002 Parameter ADDR_W, default 3, register index width; depth = 2^ADDR_W.
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 is hardwired zero.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rstN  input  1  asynchronous active-low reset.
REQ-006 readEn  input  1  captures both read ports this edge.
REQ-007 regANum, regBNum  input  ADDR_W  read port A/B indices.
REQ-008 regAOut, regBOut  output  DATA_W  registered read data.
REQ-009 regABusy, regBBusy  output  1  registered pending-write flag for the captured index.
REQ-010 writeEn  input  1  write regCIn to regCNum this edge.
REQ-011 regCNum  input  ADDR_W; regCIn  input  DATA_W  write index and data.
REQ-012 hiWriteEn  input  1; hiIn  input  DATA_W  load auxiliary high (multiply upper half) register.
REQ-013 hiOut  output  DATA_W  auxiliary high register contents.
REQ-014 reserveEn  input  1; reserveNum  input  ADDR_W  mark register pending for a multi-cycle result.
REQ-015 busyVec  output  2^ADDR_W  current pending bit per register.

Function
REQ-016 Read latency SHALL be one cycle: the edge with readEn=1 loads regAOut/regBOut; readEn=0 holds them.
REQ-017 Read-during-write to the same index on the same edge SHALL return regCIn (write-through bypass), per port independently.
REQ-018 Writes SHALL occur whenever writeEn=1, regardless of readEn.
REQ-019 ZERO_REG=1: index 0 reads 0, writes to it are discarded, no bypass for it, busy bit 0 never set.
REQ-020 hiWriteEn=1 SHALL load hiIn into the high register at the edge; hiOut is the register, no bypass; writeEn and hiWriteEn are independent.
REQ-021 reserveEn=1 SHALL set busy[reserveNum]; writeEn=1 SHALL clear busy[regCNum].
REQ-022 Simultaneous reserve and write to the same index: set wins (busy stays 1, data written).
REQ-023 regABusy loads with regAOut: busy[regANum] with same-edge write clear applied, same-edge reserve not applied; likewise port B.
REQ-024 Reserving an already-busy index SHALL leave it busy (no counting); writing a non-busy index is legal, busy stays 0.
REQ-025 Both read ports MAY address the same index; both SHALL return identical data and flags.
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 rstN=0 SHALL immediately, without clock, clear all registers, hi register, busyVec, regAOut, regBOut, regABusy, regBBusy to 0.
REQ-028 While rstN=0 all enables SHALL be ignored; first update occurs on the first rising clk with rstN=1.
REQ-029 Reset asserted mid-operation (pending reservations) SHALL discard them; busyVec=0 after reset.

Verification
REQ-030 Reset then readEn, regANum=5, regBNum=2 -> next cycle regAOut=0x00, regBOut=0x00, busy flags 0.
REQ-031 writeEn, regCNum=3, regCIn=0xA5 with readEn, regANum=3 same edge -> regAOut=0xA5 after that edge; regBNum=4 -> regBOut=0x00.
REQ-032 reserveEn reserveNum=6; next cycle read 6 -> regABusy=1, busyVec[6]=1; later writeEn 6 0x3C with readEn 6 same edge -> regAOut=0x3C, regABusy=0, busyVec[6]=0.
REQ-033 reserveEn and writeEn both index 1 same edge -> busyVec[1]=1, register 1 holds written value.
REQ-034 ZERO_REG=1: writeEn index 0 data 0xFF, then read 0 -> regAOut=0x00; hiWriteEn hiIn=0x7E -> hiOut=0x7E next cycle.
REQ-035 Write 0x11 to index 7, reserve 2, pulse rstN low between clocks -> all outputs 0 immediately, read 7 afterwards returns 0x00, busyVec=0.
